// File: rtl/rsp_s2_prep_add_pipe.sv
// Pipelined segmented unsigned adder/subtractor: one SEG_WIDTH slice resolved per stage, carry registered between stages.
// Optional build macro RSP_S2_PREP_ADD_SAT_EN enables saturation of the result in the last stage.
module rsp_s2_prep_add_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int SEG_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_vld,
  input  logic                  i_sub,
  input  logic [DATA_WIDTH-1:0] i_num1,
  input  logic [DATA_WIDTH-1:0] i_num2,
  input  logic                  i_c,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_num,
  output logic                  o_c
);

  localparam int NUM_SEG = DATA_WIDTH / SEG_WIDTH;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    logic [DATA_WIDTH-1:0] a_in, b_in, r_in;
    logic                  c_in, sub_in, vld_in;
    logic [DATA_WIDTH-1:0] a_q, b_q, r_q, r_next;
    logic                  c_q, sub_q, vld_q;
    logic [SEG_WIDTH-1:0]  a_seg, b_seg;
    logic [SEG_WIDTH:0]    seg_sum;

    // Stage 0 takes the raw inputs; later stages take the skewed operands and partial result of the previous stage.
    if (k == 0) begin : g_src
      assign a_in   = i_num1;
      assign b_in   = i_num2;
      assign r_in   = '0;
      assign c_in   = i_c;
      assign sub_in = i_sub;
      assign vld_in = i_vld;
    end else begin : g_src
      assign a_in   = g_stage[k-1].a_q;
      assign b_in   = g_stage[k-1].b_q;
      assign r_in   = g_stage[k-1].r_q;
      assign c_in   = g_stage[k-1].c_q;
      assign sub_in = g_stage[k-1].sub_q;
      assign vld_in = g_stage[k-1].vld_q;
    end

    assign a_seg   = a_in[k*SEG_WIDTH +: SEG_WIDTH];
    assign b_seg   = sub_in ? ~b_in[k*SEG_WIDTH +: SEG_WIDTH] : b_in[k*SEG_WIDTH +: SEG_WIDTH];
    assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_WIDTH{1'b0}}, c_in};

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
      r_next = r_in;
      r_next[k*SEG_WIDTH +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
`ifdef RSP_S2_PREP_ADD_SAT_EN
      // Only the top segment knows the final carry, so saturation happens here; o_c keeps the raw carry.
      if (k == NUM_SEG - 1) begin
        if (!sub_in && seg_sum[SEG_WIDTH]) begin
          r_next = '1;
        end else if (sub_in && !seg_sum[SEG_WIDTH]) begin
          r_next = '0;
        end
      end
`endif
    end

    // NOTE: every pipeline register, data included, is cleared by the async reset so no stale result can emerge.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        a_q   <= '0;
        b_q   <= '0;
        r_q   <= '0;
        c_q   <= 1'b0;
        sub_q <= 1'b0;
        vld_q <= 1'b0;
      end else if (i_en) begin
        a_q   <= a_in;
        b_q   <= b_in;
        r_q   <= r_next;
        c_q   <= seg_sum[SEG_WIDTH];
        sub_q <= sub_in;
        vld_q <= vld_in;
      end
    end
  end

  assign o_vld = g_stage[NUM_SEG-1].vld_q;
  assign o_num = g_stage[NUM_SEG-1].r_q;
  assign o_c   = g_stage[NUM_SEG-1].c_q;

endmodule

// File: tb/tb_rsp_s2_prep_add_pipe.sv
// Self-checking bench for rsp_s2_prep_add_pipe: directed vector table, random stream against a queue model,
// stall and mid-flight reset sequences. Expected values follow RSP_S2_PREP_ADD_SAT_EN when it is defined.
module tb_rsp_s2_prep_add_pipe;
  localparam int DW = 64;
  localparam int SW = 16;
  localparam int NS = DW / SW;

  logic          i_clk = 1'b0;
  logic          i_rst, i_en, i_vld, i_sub, i_c;
  logic [DW-1:0] i_num1, i_num2;
  logic          o_vld, o_c;
  logic [DW-1:0] o_num;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  rsp_s2_prep_add_pipe #(.DATA_WIDTH(DW), .SEG_WIDTH(SW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_vld(i_vld), .i_sub(i_sub),
    .i_num1(i_num1), .i_num2(i_num2), .i_c(i_c),
    .o_vld(o_vld), .o_num(o_num), .o_c(o_c)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sub;
    logic          c;
    logic [DW-1:0] num;
    logic          co;
  } vec_t;

  typedef struct {
    logic          vld;
    logic [DW-1:0] num;
    logic          co;
  } res_t;

  // One entry per enabled clock edge; the output stage shows the entry pushed NS edges ago.
  res_t model_q[$];

  function automatic res_t ref_op(logic [DW-1:0] a, logic [DW-1:0] b, logic sub, logic c, logic vld);
    res_t          r;
    logic [DW:0]   full;
    logic [DW-1:0] bb;
    bb    = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, c};
    r.vld = vld;
    r.num = full[DW-1:0];
    r.co  = full[DW];
`ifdef RSP_S2_PREP_ADD_SAT_EN
    if (!sub && r.co) r.num = '1;
    else if (sub && !r.co) r.num = '0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic sub,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c);
    i_en = en; i_vld = vld; i_sub = sub; i_num1 = a; i_num2 = b; i_c = c;
  endtask

  task automatic drive_rand(input logic en, input logic vld);
    drive(en, vld, 1'($urandom_range(1)), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)));
  endtask

  // Advance one clock edge, updating the model from the inputs sampled at that edge, then settle 1 time unit.
  task automatic tick();
    @(posedge i_clk);
    if (i_rst) begin
      model_q.delete();
    end else if (i_en) begin
      model_q.push_back(ref_op(i_num1, i_num2, i_sub, i_c, i_vld));
      if (model_q.size() > NS) void'(model_q.pop_front());
    end
    #1;
  endtask

  task automatic check_model(input string name);
    res_t e;
    e = '{vld: 1'b0, num: '0, co: 1'b0};
    if (model_q.size() == NS) e = model_q[0];
    check({name, ".vld"}, DW'(o_vld), DW'(e.vld));
    check({name, ".num"}, o_num, e.num);
    check({name, ".c"},   DW'(o_c),   DW'(e.co));
  endtask

  vec_t          vecs[7];
  int            beats;
  logic [DW-1:0] snap_num;
  logic          snap_vld, snap_c;

  initial begin
    vecs[0] = '{a: 64'd1, b: 64'd2, sub: 1'b0, c: 1'b0, num: 64'd3, co: 1'b0};
`ifdef RSP_S2_PREP_ADD_SAT_EN
    vecs[1] = '{a: '1, b: 64'd0, sub: 1'b0, c: 1'b1, num: '1, co: 1'b1};
    vecs[3] = '{a: 64'd0, b: 64'd1, sub: 1'b1, c: 1'b1, num: 64'd0, co: 1'b0};
`else
    vecs[1] = '{a: '1, b: 64'd0, sub: 1'b0, c: 1'b1, num: 64'd0, co: 1'b1};
    vecs[3] = '{a: 64'd0, b: 64'd1, sub: 1'b1, c: 1'b1, num: '1, co: 1'b0};
`endif
    vecs[2] = '{a: 64'h1_0000, b: 64'd1, sub: 1'b1, c: 1'b1, num: 64'hFFFF, co: 1'b1};
    vecs[4] = '{a: 64'h0000_FFFF_0000_FFFF, b: 64'd1, sub: 1'b0, c: 1'b0,
                num: 64'h0000_FFFF_0001_0000, co: 1'b0};
    vecs[5] = '{a: 64'd5, b: 64'd3, sub: 1'b1, c: 1'b0, num: 64'd1, co: 1'b1};
    vecs[6] = '{a: '1, b: '1, sub: 1'b0, c: 1'b1, num: '1, co: 1'b1};

    // Reset held with random inputs toggling: outputs stay zero.
    i_rst = 1'b1;
    drive_rand(1'b1, 1'b1);
    #1;
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1, 1'b1);
      tick();
      check("rst_hold.vld", DW'(o_vld), '0);
      check("rst_hold.num", o_num, '0);
      check("rst_hold.c",   DW'(o_c),   '0);
    end
    i_rst = 1'b0;

    // Directed vectors: one operation, idle cycles, result exactly NS edges after sampling.
    foreach (vecs[i]) begin
      drive(1'b1, 1'b1, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].c);
      tick();
      check_model($sformatf("vec%0d.lat1", i));
      for (int j = 1; j < NS; j++) begin
        drive_rand(1'b1, 1'b0);
        tick();
        if (j < NS - 1) check($sformatf("vec%0d.early_vld", i), DW'(o_vld), '0);
      end
      check($sformatf("vec%0d.vld", i), DW'(o_vld), 64'd1);
      check($sformatf("vec%0d.num", i), o_num, vecs[i].num);
      check($sformatf("vec%0d.c", i),   DW'(o_c), DW'(vecs[i].co));
    end

    // 100 back-to-back random operations with mixed mode.
    beats = 0;
    for (int i = 0; i < 100 + NS + 1; i++) begin
      if (i < 100) drive_rand(1'b1, 1'b1);
      else drive_rand(1'b1, 1'b0);
      tick();
      check_model("stream");
      if (o_vld) beats++;
    end
    check("stream.beats", DW'(beats), 64'd100);

    // Stall with two operations in flight.
    for (int i = 0; i < NS + 1; i++) begin
      drive_rand(1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive_rand(1'b1, 1'b1);
      tick();
      check_model("stall.fill");
    end
    snap_vld = o_vld; snap_num = o_num; snap_c = o_c;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b0, 1'b1);
      tick();
      check("stall.frozen_vld", DW'(o_vld), DW'(snap_vld));
      check("stall.frozen_num", o_num, snap_num);
      check("stall.frozen_c",   DW'(o_c), DW'(snap_c));
    end
    beats = 0;
    for (int i = 0; i < NS; i++) begin
      drive_rand(1'b1, 1'b0);
      tick();
      check_model("stall.drain");
      if (o_vld) beats++;
    end
    check("stall.beats", DW'(beats), 64'd2);

    // Mid-flight asynchronous reset pulse with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1, 1'b1);
      tick();
    end
    drive_rand(1'b1, 1'b0);
    #2;
    i_rst = 1'b1;
    model_q.delete();
    #1;
    check("arst.vld", DW'(o_vld), '0);
    check("arst.num", o_num, '0);
    check("arst.c",   DW'(o_c),   '0);
    tick();
    #2;
    i_rst = 1'b0;
    beats = 0;
    for (int i = 0; i < NS + 2; i++) begin
      drive_rand(1'b1, 1'b0);
      tick();
      check_model("arst.after");
      if (o_vld) beats++;
    end
    check("arst.stale_beats", DW'(beats), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rsp_s2_prep_add_pipe.md
# rsp_s2_prep_add_pipe

Pipelined, segmented unsigned adder/subtractor for the rsp_s2_prep datapath. It replaces single-cycle wide additions that cannot close timing. Each operand is split into SEG_WIDTH slices, and one slice is resolved per pipeline stage, with the carry registered between stages. It accepts one operation per enabled cycle, supports chaining through carry-in/carry-out, and carries a valid flag alongside the data.

## Interface
- DATA_WIDTH, 64: operand and result width. Must be an integer multiple of SEG_WIDTH.
- SEG_WIDTH, 16: bits resolved per stage. NUM_SEG = DATA_WIDTH/SEG_WIDTH, which is also the number of stages.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_en  input  1  pipeline enable. Low freezes every register, including the valid flags.
- i_vld  input  1  input operation valid; sampled when i_en=1.
- i_sub  input  1  mode: 0 computes num1+num2+i_c; 1 computes num1+~num2+i_c.
- i_num1  input  DATA_WIDTH  operand A.
- i_num2  input  DATA_WIDTH  operand B.
- i_c  input  1  carry-in. In subtract mode, i_c=1 gives a true difference and i_c=0 applies a borrow-in.
- o_vld  output  1  result valid.
- o_num  output  DATA_WIDTH  result, low DATA_WIDTH bits.
- o_c  output  1  carry-out. In subtract mode, 1 means no borrow.

## Operation
- Stage k (k=0..NUM_SEG-1) adds segment k of A and segment k of B' (B' = B, or ~B when i_sub=1) plus the carry from stage k-1. Stage 0 uses i_c as its carry.
- Skew and deskew registers:
  - Operand segments k..NUM_SEG-1 and the mode bit travel down the pipeline until they are consumed.
  - Result segments 0..k-1 travel down the pipeline until the output stage.
  - All segments of one operation leave together.
- The valid flag is shifted alongside the data and never gates the arithmetic. Data registers load on every i_en=1 cycle, whatever i_vld is.
- Arithmetic is modulo 2^DATA_WIDTH. o_c is the carry out of the top segment.
- No backpressure: the consumer must accept every o_vld=1 beat or deassert i_en.
- NUM_SEG=1 degenerates to a single registered stage of the full-width add.

## Timing
- Latency: exactly NUM_SEG enabled cycles from sampling (i_vld=1, i_en=1) to o_vld=1 with the matching o_num/o_c. With the defaults this is 4 cycles.
- Throughput: one operation per enabled cycle; back-to-back inputs produce back-to-back outputs in order.
- With i_en=0, outputs hold their values, including o_vld, and no stage advances. On re-enable the pipeline resumes with no loss or duplication.
- Reset: o_vld=0, o_num=0, o_c=0, and every internal stage register is 0, immediately on i_rst assertion, independent of i_clk.
- Reset in the middle of an operation discards all in-flight operations; none emerges after reset is released.
- The first input sampled after reset deassertion appears NUM_SEG enabled cycles later.
- Inputs are sampled only on edges where i_en=1 and i_rst=0.

## Configuration
- RSP_S2_PREP_ADD_SAT_EN defined:
  - The last stage saturates the result.
  - Add mode with carry-out=1: o_num = all ones.
  - Subtract mode with carry-out=0 (borrow): o_num = 0.
  - o_c still reports the raw carry. Latency is unchanged.
- RSP_S2_PREP_ADD_SAT_EN undefined: o_num is the wrapped modulo result, and no saturation logic is present.

## Test plan
- Reset: hold i_rst=1 with random inputs toggling -> o_vld=0, o_num=0, o_c=0 throughout. Release reset and drive A=1, B=2, i_c=0 -> o_num=3, o_c=0, o_vld=1 exactly 4 cycles later.
- Cross-segment carry: A=0xFFFF_FFFF_FFFF_FFFF, B=0, i_c=1, add mode -> o_num=0, o_c=1 after 4 cycles. With RSP_S2_PREP_ADD_SAT_EN -> o_num=0xFFFF_FFFF_FFFF_FFFF, o_c=1.
- Subtract: A=0x1_0000, B=1, i_c=1, i_sub=1 -> o_num=0xFFFF, o_c=1. A=0, B=1, i_c=1 -> wrap build: o_num=0xFFFF_FFFF_FFFF_FFFF, o_c=0; SAT build: o_num=0, o_c=0.
- Throughput and ordering: 100 back-to-back random operations with i_vld=1 and mixed i_sub -> 100 consecutive o_vld=1 beats, each matching the reference model, in input order.
- Stall: deassert i_en for 3 cycles while 2 operations are in flight -> outputs frozen during the stall; the 2 results emerge after re-enable with total latency of 4 enabled cycles.
- Mid-flight reset: pulse i_rst for 1 cycle, asynchronously between clock edges, with 3 operations in flight -> o_vld drops to 0 immediately, and no stale result appears afterwards.
